dm_access_unit: RTL and testbench

- Initiator for the word-organised data memory: takes RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) from the MEM stage.
- Drives the memory's DMaddr/DMin/DMwr port and consumes DMout, which is registered and valid one cycle after an address is presented with DMwr=0.
- Handles byte lanes, sign extension, sub-word stores by read-modify-write, and alignment/range errors.

---
 rtl/dm_access_pkg.sv | 40 ++++
 rtl/dm_lane_align.sv | 43 ++++
 rtl/dm_access_unit.sv | 108 ++++++++++
 tb/tb_dm_access_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_pkg.sv
// Shared definitions for the data-memory access unit: funct3 codes, FSM states,
// the captured-request record and the request legality check.
package dm_access_pkg;

   localparam int DEF_DM_DEPTH = 32;
   localparam int DEF_ADDR_W   = 5;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [1:0]  off;
      logic [31:0] wdata;
   } req_t;

   // Width/alignment legality only; the address range check depends on ADDR_W.
   function automatic logic f3_bad(input logic we, input logic [2:0] f3, input logic [1:0] off);
      logic illegal;
      logic mis;
      illegal = we ? (f3 > F3_SW) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      mis     = ((f3 == F3_LH || f3 == F3_LHU) && off[0]) || (f3 == F3_LW && off != 2'b00);
      return illegal || mis;
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: extracts/extends load data and merges sub-word store data.
// Purely combinational, no backpressure.
module dm_lane_align
   import dm_access_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  boff,
   input  logic [31:0] mem_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = mem_word[{boff, 3'b000} +: 8];
      lane_h = boff[1] ? mem_word[31:16] : mem_word[15:0];

      load_data = '0;
      case (funct3)
         F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
         F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
         F3_LW:   load_data = mem_word;
         F3_LBU:  load_data = {24'd0, lane_b};
         F3_LHU:  load_data = {16'd0, lane_h};
         default: load_data = '0;
      endcase

      store_word = mem_word;
      case (funct3)
         F3_SB: store_word[{boff, 3'b000} +: 8] = wdata[7:0];
         F3_SH: begin
            if (boff[1]) store_word[31:16] = wdata[15:0];
            else         store_word[15:0]  = wdata[15:0];
         end
         F3_SW:   store_word = wdata;
         default: store_word = mem_word;
      endcase
   end

endmodule

// File: rtl/dm_access_unit.sv
// Load/store initiator for a word-organised data memory with one-cycle registered reads.
// Latency err 1 / LW,LB,LH,SW 2 / SB,SH 3 cycles; req_ready only in IDLE, one request in flight.
module dm_access_unit
   import dm_access_pkg::*;
#(
   parameter int DM_DEPTH = DEF_DM_DEPTH,
   parameter int ADDR_W   = DEF_ADDR_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] DMaddr,
   output logic [31:0] DMin,
   output logic        DMwr,
   input  logic [31:0] DMout
);

   state_t            state;
   req_t              req_q;
   logic [ADDR_W-1:0] idx_q;
   logic [31:0]       din_q;
   logic              range_err;
   logic              req_err;
   logic [31:0]       load_data;
   logic [31:0]       store_word;

   always_comb begin
      range_err = ((req_addr >> (ADDR_W + 2)) != 32'd0) ||
                  (32'(req_addr[ADDR_W+1:2]) >= 32'(DM_DEPTH));
      req_err   = range_err || f3_bad(req_we, req_funct3, req_addr[1:0]);
   end

   dm_lane_align u_lane_align (
      .funct3     (req_q.funct3),
      .boff       (req_q.off),
      .mem_word   (DMout),
      .wdata      (req_q.wdata),
      .load_data  (load_data),
      .store_word (store_word)
   );

   // DMout is only valid in the cycle after READ, so the merged word and the
   // load result are taken combinationally in WRITE and RESP respectively.
   assign DMaddr    = 32'(idx_q);
   assign DMin      = (state == WRITE) ? store_word : din_q;
   assign DMwr      = (state == WRITE) && !rst;
   assign rsp_rdata = (state == RESP && !rsp_err && !req_q.we) ? load_data : 32'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         req_q     <= '0;
         idx_q     <= '0;
         din_q     <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_q     <= '{we: req_we, funct3: req_funct3, off: req_addr[1:0], wdata: req_wdata};
                  idx_q     <= req_addr[ADDR_W+1:2];
                  req_ready <= 1'b0;
                  if (req_err) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else if (req_we && req_funct3 == F3_SW) begin
                     state <= WRITE;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (req_q.we) begin
                  state <= WRITE;
               end else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end
            end
            WRITE: begin
               din_q     <= store_word;
               state     <= RESP;
               rsp_valid <= 1'b1;
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: memory model, byte-level reference model, directed and random requests.
module tb_dm_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] dm_addr;
   logic [31:0] dm_in;
   logic        dm_wr;
   logic [31:0] dm_out;

   int n_chk  = 0;
   int n_fail = 0;

   dm_access_unit dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .DMaddr     (dm_addr),
      .DMin       (dm_in),
      .DMwr       (dm_wr),
      .DMout      (dm_out)
   );

   always #5 clk = ~clk;

   // Data memory with a registered read port
   logic [31:0] tb_mem [32];
   logic        mem_clr;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 32; i++) tb_mem[i] <= 32'd0;
      end else if (dm_wr) begin
         tb_mem[dm_addr[4:0]] <= dm_in;
      end
      dm_out <= tb_mem[dm_addr[4:0]];
   end

   int          wr_cnt = 0;
   logic [31:0] wr_addr = 32'd0;
   always @(negedge clk) begin
      if (dm_wr) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= dm_addr;
      end
   end

   logic [31:0] ref_mem [32];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference: byte-addressed semantics straight from the ISA rules
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic exp_err, output logic [31:0] exp_rd,
                        output int exp_lat, output int exp_wr);
      int          size;
      int          w;
      int          sh;
      logic        legal;
      logic [31:0] v;
      legal = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      size  = 1 << f3[1:0];
      w     = int'(a[6:2]);
      sh    = int'(a[1:0]);
      exp_err = !legal || (a >= 32'd128) || ((a % size) != 0);
      exp_rd  = 32'd0;
      exp_wr  = 0;
      if (exp_err) begin
         exp_lat = 1;
      end else if (!we) begin
         exp_lat = 2;
         v = ref_mem[w] >> (8 * sh);
         if (size == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
         end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v | 32'hFFFF_0000;
         end
         exp_rd = v;
      end else begin
         exp_lat = (size == 4) ? 2 : 3;
         exp_wr  = 1;
         for (int i = 0; i < size; i++)
            ref_mem[w][8*(sh+i) +: 8] = wd[8*i +: 8];
      end
   endtask

   task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      logic        exp_err;
      logic [31:0] exp_rd;
      int          exp_lat;
      int          exp_wr;
      int          lat;
      int          wr0;
      int          spin;
      model(we, f3, a, wd, exp_err, exp_rd, exp_lat, exp_wr);
      @(negedge clk);
      spin = 0;
      while (!req_ready && spin < 10) begin
         @(negedge clk);
         spin++;
      end
      if (spin == 10) check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      wr0 = wr_cnt;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      check({tag, "_rdata"}, rsp_rdata, exp_rd);
      @(negedge clk);
      check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
      check({tag, "_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_nwr"}, 32'(wr_cnt - wr0), 32'(exp_wr));
      if (a < 32'd128) check({tag, "_mem"}, tb_mem[a[6:2]], ref_mem[a[6:2]]);
   endtask

   logic [31:0] bb_addr [3];
   logic [31:0] bb_exp  [3];
   int          acc_cyc [3];
   int          rsp_cyc [3];

   initial begin
      int n_acc;
      int n_rsp;
      int wr0;
      logic [31:0] a;
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
      rst = 1'b1; mem_clr = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", 32'(rsp_err), 32'd0);
      check("rst_dmaddr", dm_addr, 32'd0);
      check("rst_dmin", dm_in, 32'd0);
      check("rst_dmwr", 32'(dm_wr), 32'd0);
      rst = 1'b0; mem_clr = 1'b0;

      issue("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      check("sw10_dmaddr", wr_addr, 32'd4);
      issue("lw10", 1'b0, 3'd2, 32'h10, 32'h0);
      issue("sw_init1", 1'b1, 3'd2, 32'h10, 32'h8899AABB);
      issue("lb13", 1'b0, 3'd0, 32'h13, 32'h0);
      issue("lbu13", 1'b0, 3'd4, 32'h13, 32'h0);
      issue("lh12", 1'b0, 3'd1, 32'h12, 32'h0);
      issue("lhu10", 1'b0, 3'd5, 32'h10, 32'h0);
      issue("sw_init2", 1'b1, 3'd2, 32'h10, 32'h11223344);
      issue("sb11", 1'b1, 3'd0, 32'h11, 32'h000000EE);
      check("sb11_word", tb_mem[4], 32'h1122EE44);
      issue("sh12", 1'b1, 3'd1, 32'h12, 32'h0000CAFE);
      check("sh12_word", tb_mem[4], 32'hCAFEEE44);
      issue("err_lw12", 1'b0, 3'd2, 32'h12, 32'h0);
      issue("err_sh11", 1'b1, 3'd1, 32'h11, 32'h1234);
      issue("err_lw80", 1'b0, 3'd2, 32'h80, 32'h0);
      issue("err_f3_7", 1'b0, 3'd7, 32'h10, 32'h0);

      // Reset landing in the WRITE cycle of an SB must not write
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'h55;
      wr0 = wr_cnt;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("rstw_dmwr", 32'(dm_wr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("rstw_mem", tb_mem[4], ref_mem[4]);
      check("rstw_nwr", 32'(wr_cnt - wr0), 32'd0);
      check("rstw_ready", 32'(req_ready), 32'd1);
      check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rstw_rdata", rsp_rdata, 32'd0);
      check("rstw_err", 32'(rsp_err), 32'd0);
      check("rstw_dmaddr", dm_addr, 32'd0);
      check("rstw_dmin", dm_in, 32'd0);

      // Back-to-back LW with req_valid held high
      for (int i = 0; i < 3; i++) begin
         bb_addr[i] = 32'(4 * (i + 1));
         ref_mem[i+1] = 32'hA5A50000 + 32'(i);
         issue("bb_init", 1'b1, 3'd2, bb_addr[i], ref_mem[i+1]);
         bb_exp[i] = ref_mem[i+1];
      end
      @(negedge clk);
      n_acc = 0; n_rsp = 0;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = bb_addr[0];
      for (int c = 0; c < 40 && n_rsp < 3; c++) begin
         if (c > 0) @(negedge clk);
         if (rsp_valid) begin
            check("bb_rdata", rsp_rdata, bb_exp[n_rsp]);
            rsp_cyc[n_rsp] = c;
            n_rsp++;
         end
         if (n_acc > 0 && (c - acc_cyc[n_acc-1] == 1 || c - acc_cyc[n_acc-1] == 2))
            check("bb_busy", 32'(req_ready), 32'd0);
         if (req_ready && req_valid) begin
            acc_cyc[n_acc] = c;
            n_acc++;
            @(posedge clk);
            #1;
            if (n_acc < 3) req_addr = bb_addr[n_acc];
            else           req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      check("bb_nrsp", 32'(n_rsp), 32'd3);
      check("bb_nacc", 32'(n_acc), 32'd3);
      if (n_acc == 3 && n_rsp == 3) begin
         check("bb_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
         check("bb_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
         for (int i = 0; i < 3; i++)
            check("bb_lat", 32'(rsp_cyc[i] - acc_cyc[i]), 32'd2);
      end

      // Random mix of loads, stores and illegal requests
      for (int n = 0; n < 250; n++) begin
         a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
         issue("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
